// File: rtl/data_sram_responder_if.sv
// Data SRAM request/response bundle between the CPU MEM stage (master) and the responder (slave).
// en/we/addr/wdata flow toward the responder, and rdata flows back one cycle later.
interface data_sram_responder_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en,
        output data_sram_we,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_we,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// Data SRAM responder: word RAM with byte-lane writes plus LED/SWITCH/TIMER/SCRATCH MMIO window.
// Fixed 1-cycle read latency, read-first on writes, one request per cycle, no back-pressure.
module data_sram_responder #(
    parameter int          ADDR_W       = 14,
    parameter logic [15:0] MMIO_BASE_HI = 16'hbfaf,
    parameter int          LED_W        = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    data_sram_responder_if.slave  bus,
    output logic [LED_W-1:0]      led,
    input  logic [7:0]            switch,
    output logic [31:0]           timer_out
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];

    logic [31:0]       rdata_q, rdata_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic [31:0]       timer_q, timer_d;
    logic [31:0]       scratch_q, scratch_d;
    logic [7:0]        sw_meta_q, sw_sync_q;

    logic              mmio_hit;
    logic              wr;
    logic [ADDR_W-1:0] widx;
    logic [13:0]       mmio_off;
    logic [31:0]       mmio_rd;
    logic              unused_addr;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    assign mmio_hit    = (bus.data_sram_addr[31:16] == MMIO_BASE_HI);
    assign wr          = bus.data_sram_en && (bus.data_sram_we != 4'b0000);
    assign widx        = bus.data_sram_addr[ADDR_W+1:2];
    assign mmio_off    = bus.data_sram_addr[15:2];
    assign unused_addr = ^bus.data_sram_addr[1:0];

    // Register reads return pre-edge values, so a write cycle reports the old contents.
    always_comb begin
        mmio_rd = 32'h0;
        unique case (mmio_off)
            14'd0:   mmio_rd = 32'(led_q);
            14'd1:   mmio_rd = {24'h0, sw_sync_q};
            14'd2:   mmio_rd = timer_q;
            14'd3:   mmio_rd = scratch_q;
            default: mmio_rd = 32'h0;
        endcase
    end

    always_comb begin
        rdata_d   = rdata_q;
        led_d     = led_q;
        timer_d   = timer_q + 32'd1;
        scratch_d = scratch_q;
        if (bus.data_sram_en) begin
            rdata_d = mmio_hit ? mmio_rd : mem[widx];
        end
        if (wr && mmio_hit) begin
            unique case (mmio_off)
                14'd0:   led_d     = LED_W'(lane_merge(32'(led_q), bus.data_sram_wdata,
                                                       bus.data_sram_we & 4'b0011));
                14'd2:   timer_d   = lane_merge(timer_q, bus.data_sram_wdata, bus.data_sram_we);
                14'd3:   scratch_d = lane_merge(scratch_q, bus.data_sram_wdata, bus.data_sram_we);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_q   <= 32'h0;
            led_q     <= '0;
            timer_q   <= 32'h0;
            scratch_q <= 32'h0;
            sw_meta_q <= 8'h0;
            sw_sync_q <= 8'h0;
        end else begin
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            timer_q   <= timer_d;
            scratch_q <= scratch_d;
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
        end
    end

    // RAM contents survive reset, but a store presented during reset is dropped.
    always_ff @(posedge clk) begin
        if (resetn && wr && !mmio_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_we[i]) mem[widx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
            end
        end
    end

    assign bus.data_sram_rdata = rdata_q;
    assign led                 = led_q;
    assign timer_out           = timer_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: reference model checked every cycle plus literal expectations.
module tb_data_sram_responder;
    localparam int ADDR_W = 14;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] led;
    logic [7:0]  switch;
    logic [31:0] timer_out;

    int checks = 0;
    int errors = 0;

    data_sram_responder_if bus ();

    data_sram_responder #(
        .ADDR_W      (ADDR_W),
        .MMIO_BASE_HI(16'hbfaf),
        .LED_W       (16)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .led      (led),
        .switch   (switch),
        .timer_out(timer_out)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] ram_m [int];
    logic [31:0] m_rdata;
    logic [31:0] m_timer;
    logic [31:0] m_scratch;
    logic [15:0] m_led;
    logic [7:0]  sw_hist [$];
    bit          m_vld = 1'b0;

    function automatic logic [31:0] lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin : model_b
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] next_timer;
        int          idx;
        if (!resetn) begin
            m_rdata   = 32'h0;
            m_led     = 16'h0;
            m_timer   = 32'h0;
            m_scratch = 32'h0;
            sw_hist   = '{8'h0, 8'h0};
            m_vld     = 1'b1;
        end else begin
            a          = bus.data_sram_addr;
            wd         = bus.data_sram_wdata;
            be         = bus.data_sram_we;
            idx        = int'(a[ADDR_W+1:2]);
            next_timer = m_timer + 32'd1;
            if (bus.data_sram_en) begin
                if (a[31:16] == 16'hbfaf) begin
                    case (a[15:0] & 16'hfffc)
                        16'h0000: m_rdata = {16'h0, m_led};
                        16'h0004: m_rdata = {24'h0, sw_hist[1]};
                        16'h0008: m_rdata = m_timer;
                        16'h000c: m_rdata = m_scratch;
                        default:  m_rdata = 32'h0;
                    endcase
                    if (be != 4'b0) begin
                        case (a[15:0] & 16'hfffc)
                            16'h0000: m_led      = lanes({16'h0, m_led}, wd, be & 4'b0011) & 32'hffff;
                            16'h0008: next_timer = lanes(m_timer, wd, be);
                            16'h000c: m_scratch  = lanes(m_scratch, wd, be);
                            default: ;
                        endcase
                    end
                end else begin
                    m_rdata = ram_m.exists(idx) ? ram_m[idx] : 32'hxxxx_xxxx;
                    if (be != 4'b0) ram_m[idx] = lanes(m_rdata, wd, be);
                end
            end
            m_timer = next_timer;
            sw_hist.push_front(switch);
            void'(sw_hist.pop_back());
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model (unknown RAM words are not compared).
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (m_vld) begin
                if (!$isunknown(m_rdata)) chk("rdata_model", bus.data_sram_rdata, m_rdata);
                chk("led_model", {16'h0, led}, {16'h0, m_led});
                chk("timer_model", timer_out, m_timer);
            end
        end
    end

    task automatic cyc(input logic rn, input logic en, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        resetn              = rn;
        bus.data_sram_en    = en;
        bus.data_sram_we    = we;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] addr);
        cyc(1'b1, 1'b1, 4'h0, addr, 32'h0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] we);
        cyc(1'b1, 1'b1, we, addr, wd);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        resetn              = 1'b0;
        switch              = 8'h00;
        bus.data_sram_en    = 1'b0;
        bus.data_sram_we    = 4'h0;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("reset_rdata", bus.data_sram_rdata, 32'h0);
        chk("reset_led", {16'h0, led}, 32'h0);
        chk("reset_timer", timer_out, 32'h0);
        idle();
        chk("timer_after_release", timer_out, 32'h1);

        wr(32'h0000_0100, 32'h1122_3344, 4'hf);
        wr(32'h0000_0100, 32'hAABB_CCDD, 4'b0101);
        chk("read_first_old", bus.data_sram_rdata, 32'h1122_3344);
        rd(32'h0000_0100);
        chk("byte_lane_raw", bus.data_sram_rdata, 32'h11BB_33DD);
        rd(32'h0001_0100);
        chk("alias_read", bus.data_sram_rdata, 32'h11BB_33DD);
        idle();
        chk("en0_holds_rdata", bus.data_sram_rdata, 32'h11BB_33DD);

        wr(32'hbfaf_0000, 32'hFFFF_A5A5, 4'hf);
        chk("led_written", {16'h0, led}, 32'h0000_A5A5);
        rd(32'hbfaf_0000);
        chk("led_readback", bus.data_sram_rdata, 32'h0000_A5A5);

        @(negedge clk);
        switch = 8'h3C;
        for (int i = 0; i < 3; i++) idle();
        rd(32'hbfaf_0004);
        chk("switch_read", bus.data_sram_rdata, 32'h0000_003C);
        wr(32'hbfaf_0004, 32'hFFFF_FFFF, 4'hf);
        chk("switch_write_led_same", {16'h0, led}, 32'h0000_A5A5);
        rd(32'hbfaf_0004);
        chk("switch_ro", bus.data_sram_rdata, 32'h0000_003C);
        rd(32'hbfaf_0010);
        chk("unmapped_zero", bus.data_sram_rdata, 32'h0);

        wr(32'hbfaf_000c, 32'hDEAD_BEEF, 4'hf);
        wr(32'hbfaf_000c, 32'h1200_0000, 4'b1000);
        rd(32'hbfaf_000c);
        chk("scratch_lanes", bus.data_sram_rdata, 32'h12AD_BEEF);

        wr(32'hbfaf_0008, 32'hFFFF_FFFE, 4'hf);
        chk("timer_load", timer_out, 32'hFFFF_FFFE);
        idle();
        chk("timer_ff", timer_out, 32'hFFFF_FFFF);
        idle();
        chk("timer_wrap", timer_out, 32'h0000_0000);
        idle();
        chk("timer_after_wrap", timer_out, 32'h0000_0001);
        rd(32'hbfaf_0008);
        chk("timer_read_pre_edge", bus.data_sram_rdata, 32'h0000_0001);

        wr(32'h0000_0200, 32'h5566_7788, 4'hf);
        rd(32'h0000_0200);
        chk("b2b_raw", bus.data_sram_rdata, 32'h5566_7788);

        rd(32'h0000_0100);
        cyc(1'b0, 1'b1, 4'h0, 32'h0000_0100, 32'h0);
        chk("reset_drops_read", bus.data_sram_rdata, 32'h0);
        chk("reset_clears_led", {16'h0, led}, 32'h0);
        cyc(1'b0, 1'b1, 4'hf, 32'h0000_0100, 32'hDEAD_BEEF);
        rd(32'h0000_0100);
        chk("ram_kept_over_reset", bus.data_sram_rdata, 32'h11BB_33DD);
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
Responder end of the CPU data SRAM interface (en / we / addr / wdata -> rdata). It services loads and stores from the EXE/MEM stages with a fixed 1-cycle read latency. It holds a word-addressed RAM with byte-lane writes, plus a small MMIO register window (LED, switch, free-running timer, scratch). It sits beside mycpu_top at SoC level and feeds data_sram_rdata back to the MEM stage.

Parameters:
ADDR_W, 14, RAM word-index width (2^ADDR_W words; 14 -> 64 KB)
MMIO_BASE_HI, 16'hbfaf, addr[31:16] value that selects the MMIO window
LED_W, 16, width of LED register and led output

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
data_sram_en  input  1  access request this cycle
data_sram_we  input  4  byte write enables; lane i = wdata[8i+7:8i]
data_sram_addr  input  32  byte address; bits [1:0] ignored
data_sram_wdata  input  32  store data
data_sram_rdata  output  32  read data, valid the cycle after the request
led  output  LED_W  LED register value
switch  input  8  asynchronous switch inputs
timer_out  output  32  current timer value

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low on resetn. All state updates on the rising edge of clk.
- Decode: mmio_hit = (addr[31:16] == MMIO_BASE_HI). Otherwise the access targets RAM[addr[ADDR_W+1:2]]. Upper address bits outside the window are ignored, so RAM aliases.
- Read: en=1 and we=4'b0 at cycle N -> rdata holds the selected word from edge N+1 until the next edge. No stalls and no back-pressure.
- Write: en=1 and we!=0 updates only the lanes whose we bit is 1. Writes are read-first: rdata after a write cycle equals the word's old value.
- en=0: no state change to RAM or registers (timer still counts); rdata holds its previous value.
- MMIO offsets (addr[15:0]):
  - 0x0 LED: RW; lanes 0-1 writable; upper bits read 0.
  - 0x4 SWITCH: RO; returns the synchronised switch value zero-extended; writes are ignored.
  - 0x8 TIMER: RW with byte lanes.
  - 0xC SCRATCH: RW with byte lanes.
  - Any other offset reads 32'h0; writes are ignored.
- Switch path: 2-flop synchroniser, so the visible value lags the pin by 2 cycles.
- Timer:
  - Increments by 1 every cycle and wraps 32'hffff_ffff -> 0.
  - On a write cycle, the merged written value is loaded instead of the increment, and counting resumes from it next cycle.
  - A read returns the pre-edge value: the value at cycle N.
- Reset (resetn=0 at an edge):
  - rdata, led, timer, scratch and synchroniser flops all go to 0.
  - RAM contents are not reset.
  - Any request presented in the reset cycle is discarded, including a pending read (rdata=0 next cycle).
  - The first request is honoured in the cycle resetn=1.
- Back-to-back requests (one per cycle, any mix of read/write and RAM/MMIO) are fully supported. A read directly after a write to the same word returns the new data.

Test Plan:
- Reset then RAM read: hold resetn=0 for 3 cycles -> rdata=0, led=0, timer_out=0. Release; the next cycle timer_out=1.
- Byte-lane store then load: write 32'h1122_3344 to 0x0000_0100 with we=4'hf. Then write wdata=32'hAABB_CCDD with we=4'b0101 to the same address. Then read it -> rdata=32'h11BB_33DD one cycle after the read request.
- Read-first and RAW:
  - The write cycle of the previous scenario shows rdata=32'h1122_3344 (old value).
  - An immediately following read of the same address returns 32'h11BB_33DD.
  - Aliasing: reading 0x0001_0100 with ADDR_W=14 also returns 32'h11BB_33DD.
- LED/SWITCH MMIO:
  - Write 32'hFFFF_A5A5 we=4'hf to 0xbfaf_0000 -> led=16'hA5A5; a read of it returns 32'h0000_A5A5.
  - Drive switch=8'h3C and wait 3 cycles; a read of 0xbfaf_0004 returns 32'h0000_003C.
  - Writing 0xbfaf_0004 changes nothing.
  - Reading 0xbfaf_0010 returns 0.
- Timer load and wrap: write 32'hFFFF_FFFE to 0xbfaf_0008 -> timer_out sequence FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001 on the following edges.
- Reset mid-access: issue a read of 0x100 with resetn=0 in the same cycle -> rdata=0 the next cycle. RAM word 0x100 is unchanged when read after reset.
